mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL take one parameter: WIDTH, default 32, operand and HI/LO width, legal range 4..64.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 The block SHALL have port clk, input, 1 bit: clock, all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request, sampled with op/a/b.
REQ-006 The block SHALL have port op, input, 3 bits: 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 110/111 no-op.
REQ-007 The block SHALL have port a, input, WIDTH bits: multiplicand, dividend, or MTHI/MTLO data.
REQ-008 The block SHALL have port b, input, WIDTH bits: multiplier or divisor.
REQ-009 The block SHALL have port busy, output, 1 bit: operation in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when a MULT/DIV result is committed.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: the last committed divide had b==0.
REQ-012 The block SHALL have port hi, output, WIDTH bits: registered HI.
REQ-013 The block SHALL have port lo, output, WIDTH bits: registered LO.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, FIX; busy=1 exactly in RUN and FIX.
REQ-015 start is accepted only in IDLE; start in RUN/FIX SHALL be ignored, with no queueing and no effect on operands.
REQ-016 An accepted MULT/MULTU/DIV/DIVU SHALL latch a, b, and op, and enter RUN with iteration counter = WIDTH.
REQ-017 RUN SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per cycle and decrement the counter; after WIDTH cycles the FSM SHALL go to FIX.
REQ-018 For signed ops, iteration SHALL run on magnitudes; FIX SHALL apply sign correction and leave for IDLE.
REQ-019 Latency: with start accepted at edge E, busy SHALL be high for exactly WIDTH+1 cycles.
REQ-020 hi, lo, and div_by_zero SHALL update at the edge leaving FIX, and done SHALL be 1 for the single following cycle.
REQ-021 hi/lo SHALL hold their previous values throughout RUN/FIX; no partial results SHALL be visible.
REQ-022 MULTU: {hi,lo} SHALL be the full 2*WIDTH-bit unsigned product.
REQ-023 MULT: {hi,lo} SHALL be the 2*WIDTH-bit two's-complement product.
REQ-024 DIVU: lo SHALL be the unsigned quotient and hi the remainder.
REQ-025 DIV: lo SHALL be the quotient truncated toward zero, and hi the remainder with the sign of the dividend (|hi| < |b|).
REQ-026 DIV with a=most-negative and b=-1 SHALL produce lo=most-negative, hi=0, div_by_zero=0.
REQ-027 Divide with b==0 SHALL still take WIDTH+1 busy cycles, then produce hi=a, lo=all ones, div_by_zero=1.
REQ-028 A non-divide MULT commit SHALL clear div_by_zero; MTHI/MTLO SHALL leave it unchanged.
REQ-029 MTHI/MTLO with start in IDLE SHALL write a to hi/lo at that edge, with busy=0 and no done pulse; the other register SHALL be unchanged.
REQ-030 MTHI/MTLO in RUN/FIX SHALL be ignored.
REQ-031 No-op codes SHALL have no effect in any state.
REQ-032 A new start in the same cycle done=1 SHALL be accepted, giving back-to-back operation.

Reset
REQ-033 rst_n=0 at a rising edge SHALL force IDLE, counter=0, busy=0, done=0, div_by_zero=0, hi=0, lo=0, regardless of state.
REQ-034 Reset mid-operation SHALL abandon the operation with no done pulse and no result commit.
REQ-035 start while rst_n=0 SHALL be ignored.

Verification (WIDTH=32)
REQ-036 MULT a=0xFFFFFFFE, b=0x3 -> busy 33 cycles, then done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-037 MULTU a=0xFFFFFFFE, b=0x3 -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-038 DIV a=0xFFFFFFF9, b=0x2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-039 DIVU a=0x7, b=0 -> after 33 busy cycles, hi=0x7, lo=0xFFFFFFFF, div_by_zero=1; then MULTU 2x3 -> div_by_zero=0, lo=0x6.
REQ-040 MTHI a=0x1234 in IDLE -> hi=0x1234 next cycle, lo unchanged, no done; MTLO during MULT busy -> lo unchanged, MULT result unaffected.
REQ-041 rst_n=0 at RUN cycle 10 -> next cycle busy=0, hi=lo=0, and no done for the following 40 cycles.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Ports: clk, rst_n, start, op, a, b -> busy, done, div_by_zero, hi, lo.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] m;
   logic [WIDTH-1:0] a_raw;
   logic             is_div;
   logic             neg_p;
   logic             neg_r;
   logic             bz;

   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   msum;
   logic [WIDTH:0]   dsh;
   logic [WIDTH-1:0] ddiff;
   logic             dge;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_f;
   logic [WIDTH-1:0] quo_f;
   logic [WIDTH-1:0] rem_f;

   always_comb begin
      a_neg = op[0] & a[WIDTH-1];
      b_neg = op[0] & b[WIDTH-1];
      a_mag = a_neg ? -a : a;
      b_mag = b_neg ? -b : b;
      // multiply: acc is the running upper half, q holds the
      // multiplier and collects product bits from the top
      msum  = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
      // divide: q holds the dividend and collects quotient bits
      dsh   = {acc, q[WIDTH-1]};
      dge   = (dsh >= {1'b0, m});
      ddiff = dsh[WIDTH-1:0] - m;
      prod   = {acc, q};
      prod_f = neg_p ? -prod : prod;
      quo_f  = neg_p ? -q : q;
      rem_f  = neg_r ? -acc : acc;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         acc         <= '0;
         q           <= '0;
         m           <= '0;
         a_raw       <= '0;
         is_div      <= 1'b0;
         neg_p       <= 1'b0;
         neg_r       <= 1'b0;
         bz          <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  unique case (op)
                     3'b000, 3'b001, 3'b010, 3'b011: begin
                        m      <= op[1] ? b_mag : a_mag;
                        q      <= op[1] ? a_mag : b_mag;
                        acc    <= '0;
                        a_raw  <= a;
                        is_div <= op[1];
                        neg_p  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        bz     <= (b == '0);
                        cnt    <= CW'(WIDTH);
                        busy   <= 1'b1;
                        state  <= RUN;
                     end
                     3'b100:  hi <= a;
                     3'b101:  lo <= a;
                     default: ;
                  endcase
               end
            end
            RUN: begin
               if (is_div) begin
                  acc <= dge ? ddiff : dsh[WIDTH-1:0];
                  q   <= {q[WIDTH-2:0], dge};
               end else begin
                  acc <= msum[WIDTH:1];
                  q   <= {msum[0], q[WIDTH-1:1]};
               end
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1))
                  state <= FIX;
            end
            FIX: begin
               // zero divisor: dividend goes to HI, LO saturates
               if (is_div && bz) begin
                  hi <= a_raw;
                  lo <= '1;
               end else if (is_div) begin
                  hi <= rem_f;
                  lo <= quo_f;
               end else begin
                  {hi, lo} <= prod_f;
               end
               div_by_zero <= is_div & bz;
               done        <= 1'b1;
               busy        <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit at WIDTH=32.
// Directed vectors; monitor checks every done pulse against the queue.
module tb_mult_div_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic         div_by_zero;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;
   logic         m_dbz = 1'b0;

   always #5 clk = ~clk;

   mult_div_unit #(.WIDTH(W)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .op(op),
      .a(a),
      .b(b),
      .busy(busy),
      .done(done),
      .div_by_zero(div_by_zero),
      .hi(hi),
      .lo(lo)
   );

   task automatic chk(input string name, input logic [W-1:0] act,
                      input logic [W-1:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (done) begin
         exp_t e;
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got 1 expected 0");
         end else begin
            e = sb.pop_front();
            chk("res_hi", hi, e.hi);
            chk("res_lo", lo, e.lo);
            chk("res_dbz", W'(div_by_zero), W'(e.dbz));
         end
      end
   end

   task automatic issue(input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] eh,
                        input logic [W-1:0] el, input logic ed);
      exp_t e;
      e.hi = eh;
      e.lo = el;
      e.dbz = ed;
      sb.push_back(e);
      op = o;
      a = x;
      b = y;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // counts busy cycles; optional MTLO injected mid-operation
   task automatic wait_commit(input string name, input int mtlo_at,
                              input logic [W-1:0] eh,
                              input logic [W-1:0] el, input logic ed);
      int n = 0;
      bit held = 1'b1;
      while (busy && n < 200) begin
         n++;
         if (hi !== m_hi || lo !== m_lo) held = 1'b0;
         if (n == mtlo_at) begin
            op = 3'b101;
            a = 32'hDEAD_BEEF;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk({name, "_busy_cycles"}, W'(n), W'(33));
      chk({name, "_hold"}, W'(held), W'(1));
      chk({name, "_done"}, W'(done), W'(1));
      m_hi = eh;
      m_lo = el;
      m_dbz = ed;
   endtask

   task automatic run_op(input string name, input logic [2:0] o,
                         input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] eh,
                         input logic [W-1:0] el, input logic ed,
                         input int mtlo_at);
      issue(o, x, y, eh, el, ed);
      wait_commit(name, mtlo_at, eh, el, ed);
   endtask

   initial begin
      int nd;
      rst_n = 1'b0;
      start = 1'b1;
      op = 3'b000;
      a = 32'h5;
      b = 32'h7;
      repeat (3) @(negedge clk);
      chk("rst_busy", W'(busy), W'(0));
      chk("rst_done", W'(done), W'(0));
      chk("rst_dbz", W'(div_by_zero), W'(0));
      chk("rst_hi", hi, '0);
      chk("rst_lo", lo, '0);
      start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_start_ignored", W'(busy), W'(0));

      run_op("mult", 3'b001, 32'hFFFF_FFFE, 32'h3,
             32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, -1);
      run_op("multu", 3'b000, 32'hFFFF_FFFE, 32'h3,
             32'h2, 32'hFFFF_FFFA, 1'b0, -1);
      run_op("div_neg", 3'b011, 32'hFFFF_FFF9, 32'h2,
             32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, -1);
      run_op("div_ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF,
             32'h0, 32'h8000_0000, 1'b0, -1);
      run_op("divu_zero", 3'b010, 32'h7, 32'h0,
             32'h7, 32'hFFFF_FFFF, 1'b1, -1);
      run_op("multu_clr", 3'b000, 32'h2, 32'h3,
             32'h0, 32'h6, 1'b0, -1);
      run_op("divu", 3'b010, 32'd100, 32'd7,
             32'd2, 32'd14, 1'b0, -1);
      run_op("div_negb", 3'b011, 32'h7, 32'hFFFF_FFFE,
             32'h1, 32'hFFFF_FFFD, 1'b0, -1);
      run_op("mult_mm", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'h0, 32'h1, 1'b0, -1);
      run_op("mult_mtlo", 3'b001, 32'h1234_5678, 32'h10,
             32'h1, 32'h2345_6780, 1'b0, 5);
      run_op("div_zero", 3'b011, 32'h5, 32'h0,
             32'h5, 32'hFFFF_FFFF, 1'b1, -1);

      // MTHI issued in the done cycle
      op = 3'b100;
      a = 32'h1234;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("mthi_hi", hi, 32'h1234);
      chk("mthi_lo", lo, m_lo);
      chk("mthi_busy", W'(busy), W'(0));
      chk("mthi_done", W'(done), W'(0));
      chk("mthi_dbz", W'(div_by_zero), W'(m_dbz));
      m_hi = 32'h1234;

      op = 3'b101;
      a = 32'hCAFE;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("mtlo_lo", lo, 32'hCAFE);
      chk("mtlo_hi", hi, m_hi);
      m_lo = 32'hCAFE;

      op = 3'b110;
      a = 32'h9999;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("nop_busy", W'(busy), W'(0));
      chk("nop_hi", hi, m_hi);
      chk("nop_lo", lo, m_lo);

      // reset in the middle of a run
      issue(3'b000, 32'h3, 32'h4, 32'h0, 32'hC, 1'b0);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      void'(sb.pop_back());
      chk("midrst_busy", W'(busy), W'(0));
      chk("midrst_hi", hi, '0);
      chk("midrst_lo", lo, '0);
      chk("midrst_dbz", W'(div_by_zero), W'(0));
      rst_n = 1'b1;
      m_hi = '0;
      m_lo = '0;
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) nd++;
         @(negedge clk);
      end
      chk("midrst_nodone", W'(nd), W'(0));

      run_op("after_rst", 3'b000, 32'h3, 32'h4,
             32'h0, 32'hC, 1'b0, -1);
      @(negedge clk);
      chk("sb_empty", W'(sb.size()), W'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
